clkdiv_multi: RTL and testbench
===============================

Name: clkdiv_multi

Overview:
Multi-channel, run-time programmable clock-enable generator. It is the parametrised successor to the single-channel divided-tick generator. Each of NCH independent channels produces a one-cycle tick every (div+1) clocks and, optionally, a 50%-duty divided square wave. Divisor changes are glitch-free via a per-channel shadow register. A global sync input phase-aligns all channels. It sits in libfpga/mem and feeds UART baud, SDRAM refresh and timer prescalers from the single system clock.

Parameters:
NCH, 4, number of independent channels (1..16)
W, 21, divisor/counter width in bits

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
en  input  NCH  per-channel enable; bit i controls channel i
div  input  NCH*W  packed divisors; channel i uses div[i*W +: W]; period = div+1 clocks
mode  input  NCH  per-channel clkout mode: 0 = clkout held 0, 1 = square wave toggling at terminal count
sync  input  1  synchronous restart of all enabled channels
tick  output  NCH  registered one-cycle pulse at each terminal count
clkout  output  NCH  registered divided square wave (mode=1), period 2*(div+1)

Behaviour:
- Reset (reset_n=0, asynchronous): cnt=0, shadow=0, tick=0, clkout=0 for all channels. Outputs are registers only; no combinational path from inputs to tick/clkout.
- Per-channel priority on each edge: reset > disabled > sync > count.
- Disabled (en[i]=0):
  - cnt=0, tick=0, clkout=0.
  - shadow<=div_i every cycle, so a channel starts with the divisor present when it is enabled.
- Sync (sync=1, channel enabled):
  - cnt<=0, tick<=0, clkout<=0, shadow<=div_i.
  - After sync deasserts, all enabled channels with equal div tick on the same cycle.
- Count (enabled, no sync):
  - If cnt<shadow: cnt<=cnt+1, tick<=0.
  - Else (terminal count): cnt<=0, tick<=1, shadow<=div_i, and clkout<=~clkout if mode[i]=1, else clkout<=0.
- Timing: tick is high in the cycle following the edge at which cnt==shadow. The first tick follows the (div+1)th enabled edge. Steady-state tick period is div+1 clocks, high for exactly 1 cycle.
- div=0: tick stays high continuously from the first enabled edge; clkout toggles every cycle (period 2).
- div=all-ones: the counter reaches 2^W-1 without overflow. The comparison is W-bit unsigned and cnt never exceeds shadow.
- Divisor change mid-period: the new div is ignored until the current period's terminal count, then takes effect for the next period. Periods are never truncated or stretched.
- mode change mid-operation:
  - Switching to 0 forces clkout to 0 at the next terminal count.
  - Switching to 1 starts toggling from 0 at the next terminal count.
  - tick is unaffected by mode.
- en deassert mid-period: outputs go to 0 on the next edge. Re-enable restarts the period from cnt=0.
- Reset mid-operation: all outputs go to 0 immediately (asynchronously). Counting resumes from cnt=0 with a fresh shadow load once reset_n is deasserted.
- Channels are fully independent except for the shared sync and reset.

Test Plan:
- Pulse, ch0: div=3, en[0]=1 -> tick[0] high for 1 cycle after enabled edges 4, 8, 12; clkout[0]=0 throughout.
- Square, ch1: div=1, mode[1]=1 -> clkout[1] toggles after edges 2, 4, 6 (period 4 clocks, 50% duty); tick[1] every 2 cycles.
- div=0, ch2 -> tick[2] constant 1 from the first enabled edge; with mode=1, clkout[2] alternates every cycle.
- Divisor change: ch0 running div=5, div written to 2 at cnt=2 -> current period still ends at 6 clocks; following ticks every 3 clocks.
- Sync: ch0 div=4 and ch3 div=4 enabled 2 cycles apart, pulse sync for 1 cycle -> tick[0] and tick[3] coincide 5 cycles after sync deasserts.
- Async reset asserted mid-period between edges -> tick, clkout go 0 immediately without waiting for clk; after release with div=3, first tick follows the 4th edge.

Source files
------------

// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - multi-channel programmable tick / divided-clock generator
// Each channel ticks every (div+1) clocks; divisor changes take effect at terminal count.
module clkdiv_multi #(
  parameter int NCH = 4,
  parameter int W   = 21
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NCH-1:0]   en,
  input  logic [NCH*W-1:0] div,
  input  logic [NCH-1:0]   mode,
  input  logic             sync,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   clkout
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [W-1:0] cnt;
    logic [W-1:0] shadow;
    logic [W-1:0] div_i;
    logic [W-1:0] lim;
    logic         primed;
    logic         tick_r;
    logic         clkout_r;

    assign div_i = div[i*W +: W];
    // Right after reset the shadow is still zero; use the live divisor for that first period.
    assign lim   = primed ? shadow : div_i;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt      <= '0;
        shadow   <= '0;
        primed   <= 1'b0;
        tick_r   <= 1'b0;
        clkout_r <= 1'b0;
      end else if (!en[i] || sync) begin
        cnt      <= '0;
        shadow   <= div_i;
        primed   <= 1'b1;
        tick_r   <= 1'b0;
        clkout_r <= 1'b0;
      end else if (cnt < lim) begin
        cnt    <= cnt + 1'b1;
        tick_r <= 1'b0;
        if (!primed) begin
          shadow <= div_i;
          primed <= 1'b1;
        end
      end else begin
        cnt      <= '0;
        tick_r   <= 1'b1;
        shadow   <= div_i;
        primed   <= 1'b1;
        clkout_r <= mode[i] ? ~clkout_r : 1'b0;
      end
    end

    assign tick[i]   = tick_r;
    assign clkout[i] = clkout_r;
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb/tb_clkdiv_multi.sv - self-checking bench for clkdiv_multi
module tb_clkdiv_multi;
  localparam int NCH = 4;
  localparam int W   = 5;

  logic             clk;
  logic             reset_n;
  logic [NCH-1:0]   en;
  logic [NCH*W-1:0] div;
  logic [NCH-1:0]   mode;
  logic             sync;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   clkout;

  clkdiv_multi #(.NCH(NCH), .W(W)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .div(div), .mode(mode),
    .sync(sync), .tick(tick), .clkout(clkout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clkout;
    string          tag;
  } exp_t;

  typedef struct {
    int   ch;
    int   dv;
    logic md;
    int   ncyc;
  } vec_t;

  exp_t sbq[$];
  int   checks;
  int   failures;

  task automatic expect_next(input logic [NCH-1:0] t, input logic [NCH-1:0] c, input string tag);
    exp_t e;
    e.tick   = t;
    e.clkout = c;
    e.tag    = tag;
    sbq.push_back(e);
  endtask

  task automatic check(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic edge_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty got=0 exp=1");
    end else begin
      e = sbq.pop_front();
      check({e.tag, "_tick"}, tick, e.tick);
      check({e.tag, "_clkout"}, clkout, e.clkout);
    end
  endtask

  task automatic set_div(input int ch, input int v);
    div[ch*W +: W] = v[W-1:0];
  endtask

  vec_t           vecs[6];
  logic [NCH-1:0] et;
  logic [NCH-1:0] ec;
  int             p;
  logic [7:0]     mc_exp;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{ch: 0, dv: 3,  md: 1'b0, ncyc: 13};
    vecs[1] = '{ch: 1, dv: 1,  md: 1'b1, ncyc: 8};
    vecs[2] = '{ch: 2, dv: 0,  md: 1'b1, ncyc: 6};
    vecs[3] = '{ch: 3, dv: 0,  md: 1'b0, ncyc: 4};
    vecs[4] = '{ch: 1, dv: 2,  md: 1'b1, ncyc: 13};
    vecs[5] = '{ch: 0, dv: 31, md: 1'b1, ncyc: 70};

    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    en       = '0;
    div      = '0;
    mode     = '0;
    sync     = 1'b0;

    expect_next('0, '0, "reset");
    edge_check();
    reset_n = 1'b1;

    // Steady-state periods: tick after every (div+1)th enabled edge, clkout toggles on each tick.
    for (int vi = 0; vi < 6; vi++) begin
      en   = '0;
      mode = '0;
      div  = '0;
      set_div(vecs[vi].ch, vecs[vi].dv);
      mode[vecs[vi].ch] = vecs[vi].md;
      expect_next('0, '0, $sformatf("vec%0d_idle", vi));
      edge_check();
      en[vecs[vi].ch] = 1'b1;
      p = vecs[vi].dv + 1;
      for (int k = 1; k <= vecs[vi].ncyc; k++) begin
        et = '0;
        ec = '0;
        et[vecs[vi].ch] = ((k % p) == 0);
        ec[vecs[vi].ch] = vecs[vi].md && (((k / p) % 2) == 1);
        expect_next(et, ec, $sformatf("vec%0d_k%0d", vi, k));
        edge_check();
      end
    end

    // Divisor change mid-period: 5 -> 2 written at cnt=2.
    en = '0; mode = '0; div = '0;
    set_div(0, 5);
    expect_next('0, '0, "divchg_idle");
    edge_check();
    en[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      et = '0;
      et[0] = (k == 6) || (k > 6 && ((k - 6) % 3) == 0);
      expect_next(et, '0, $sformatf("divchg_k%0d", k));
      edge_check();
      if (k == 2) set_div(0, 2);
    end

    // Mode change on ch1, div=1: off after edge 3, back on after edge 6.
    en = '0; mode = '0; div = '0;
    set_div(1, 1);
    mode[1] = 1'b1;
    expect_next('0, '0, "mode_idle");
    edge_check();
    en[1] = 1'b1;
    mc_exp = 8'b1000_0110;
    for (int k = 1; k <= 8; k++) begin
      et = '0;
      ec = '0;
      et[1] = ((k % 2) == 0);
      ec[1] = mc_exp[k-1];
      expect_next(et, ec, $sformatf("mode_k%0d", k));
      edge_check();
      if (k == 3) mode[1] = 1'b0;
      if (k == 6) mode[1] = 1'b1;
    end

    // Sync: ch0 and ch3 (div=4) enabled two cycles apart, then aligned.
    en = '0; mode = '0; div = '0;
    set_div(0, 4);
    set_div(3, 4);
    expect_next('0, '0, "sync_idle");
    edge_check();
    en[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      expect_next('0, '0, $sformatf("sync_pre%0d", k));
      edge_check();
    end
    en[3] = 1'b1;
    expect_next('0, '0, "sync_pre2");
    edge_check();
    sync = 1'b1;
    expect_next('0, '0, "sync_pulse");
    edge_check();
    sync = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      expect_next((k == 5) ? 4'b1001 : 4'b0000, '0, $sformatf("sync_k%0d", k));
      edge_check();
    end

    // Async reset between edges, then restart with div=3.
    en = '0; mode = '0; div = '0;
    set_div(0, 3);
    mode[0] = 1'b1;
    expect_next('0, '0, "rst_idle");
    edge_check();
    en[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      expect_next((k == 4) ? 4'b0001 : 4'b0000, (k == 4) ? 4'b0001 : 4'b0000,
                  $sformatf("rst_pre%0d", k));
      edge_check();
    end
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_async_tick", tick, '0);
    check("rst_async_clkout", clkout, '0);
    expect_next('0, '0, "rst_held");
    edge_check();
    reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      expect_next((k == 4) ? 4'b0001 : 4'b0000, (k >= 4) ? 4'b0001 : 4'b0000,
                  $sformatf("rst_post%0d", k));
      edge_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
